// File: rtl/uart_rx_cfg_if.sv
// Receive-side bundle between the UART receiver and its consumer: the serial
// line, the valid/ready word handshake and the per-word status flags.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_uart;
    logic                 rx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rx_uart,
        output rx_ready,
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  break_det,
        input  overrun,
        input  busy
    );

    modport slave (
        input  rx_uart,
        input  rx_ready,
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output break_det,
        output overrun,
        output busy
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 3-sample majority vote per bit, optional parity,
// 1 or 2 stop bits, break/overrun reporting and a one-entry holding register.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_rx_cfg_if.slave io_rx
);

    localparam int MID   = (CLKS_PER_BIT - 1) / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = 4;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_VOTE0  = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_VOTE1  = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(MID + 1);
    localparam logic [IDX_W-1:0] IDX_DLAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_SLAST  = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_vote0;
    logic                 r_vote1;
    logic [IDX_W-1:0]     r_bitIdx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parityBit;
    logic                 r_parityErr;
    logic                 r_frameErr;

    logic [DATA_BITS-1:0] r_rxData;
    logic                 r_rxValid;
    logic                 r_parErrOut;
    logic                 r_frameErrOut;
    logic                 r_breakDet;
    logic                 r_overrun;

    logic   w_rxS;
    logic   w_decide;
    logic   w_majority;
    logic   w_parityExp;
    logic   w_frameErrNow;
    logic   w_complete;
    logic   w_break;
    state_t w_stateNext;

    assign w_rxS         = r_sync2;
    assign w_decide      = (r_cnt == CNT_DECIDE);
    assign w_majority    = (r_vote0 & r_vote1) | (r_vote0 & w_rxS) | (r_vote1 & w_rxS);
    assign w_parityExp   = (PARITY_MODE == 2) ? (^r_shift) : ~(^r_shift);
    assign w_frameErrNow = r_frameErr | ~w_majority;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= io_rx.rx_uart;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // All bit-level transitions happen in the decision cycle; the bit counter
    // free-runs across bits so the next decision lands one period later.
    always_comb begin
        w_stateNext = r_state;
        w_complete  = 1'b0;
        w_break     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rxS) begin
                    w_stateNext = START;
                end
            end
            START: begin
                if (w_decide) begin
                    w_stateNext = w_majority ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_decide && (r_bitIdx == IDX_DLAST)) begin
                    w_stateNext = (PARITY_MODE != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_decide) begin
                    w_stateNext = STOP;
                end
            end
            STOP: begin
                if (w_decide && (r_bitIdx == IDX_SLAST)) begin
                    w_complete  = 1'b1;
                    w_break     = (r_shift == '0) && ((PARITY_MODE == 0) || !r_parityBit)
                                  && w_frameErrNow;
                    w_stateNext = w_frameErrNow ? WAIT_HIGH : IDLE;
                end
            end
            WAIT_HIGH: begin
                if (w_rxS) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_vote0 <= 1'b1;
            r_vote1 <= 1'b1;
        end else begin
            if ((r_state == IDLE) || (r_state == WAIT_HIGH)) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_cnt == CNT_VOTE0) begin
                r_vote0 <= w_rxS;
            end
            if (r_cnt == CNT_VOTE1) begin
                r_vote1 <= w_rxS;
            end
        end
    end

    // Per-frame accumulation: bit index, shift register, parity and stop status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitIdx    <= '0;
            r_shift     <= '0;
            r_parityBit <= 1'b0;
            r_parityErr <= 1'b0;
            r_frameErr  <= 1'b0;
        end else if (r_state == IDLE) begin
            r_bitIdx    <= '0;
            r_parityBit <= 1'b0;
            r_parityErr <= 1'b0;
            r_frameErr  <= 1'b0;
        end else if (w_decide) begin
            if ((r_state == START) || (r_state == PARITY) ||
                ((r_state == DATA) && (r_bitIdx == IDX_DLAST))) begin
                r_bitIdx <= '0;
            end else begin
                r_bitIdx <= r_bitIdx + IDX_W'(1);
            end
            if (r_state == DATA) begin
                r_shift <= {w_majority, r_shift[DATA_BITS-1:1]};
            end
            if (r_state == PARITY) begin
                r_parityBit <= w_majority;
                r_parityErr <= (w_majority != w_parityExp);
            end
            if ((r_state == STOP) && !w_majority) begin
                r_frameErr <= 1'b1;
            end
        end
    end

    // Holding register: a completed frame loads if the slot is free or being
    // emptied this cycle, otherwise it is dropped and reported as overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxData      <= '0;
            r_rxValid     <= 1'b0;
            r_parErrOut   <= 1'b0;
            r_frameErrOut <= 1'b0;
            r_breakDet    <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_breakDet <= 1'b0;
            r_overrun  <= 1'b0;
            if (w_complete && w_break) begin
                r_breakDet <= 1'b1;
            end else if (w_complete) begin
                if (!r_rxValid || io_rx.rx_ready) begin
                    r_rxData      <= r_shift;
                    r_rxValid     <= 1'b1;
                    r_parErrOut   <= r_parityErr;
                    r_frameErrOut <= w_frameErrNow;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rxValid && io_rx.rx_ready) begin
                r_rxValid     <= 1'b0;
                r_parErrOut   <= 1'b0;
                r_frameErrOut <= 1'b0;
            end
        end
    end

    assign io_rx.rx_data    = r_rxData;
    assign io_rx.rx_valid   = r_rxValid;
    assign io_rx.parity_err = r_parErrOut;
    assign io_rx.frame_err  = r_frameErrOut;
    assign io_rx.break_det  = r_breakDet;
    assign io_rx.overrun    = r_overrun;
    assign io_rx.busy       = (r_state != IDLE);

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. Supports configurable data width, parity and stop-bit count, and takes a 3-sample majority vote at each bit centre. Reports parity error, framing error, break and overrun. Sits between the board RX pin and the command/packet parser in the serial interface, and delivers bytes over a valid/ready handshake with a one-entry holding register.

Parameters:
CLKS_PER_BIT, 868, clocks per bit period (100 MHz / 115200); must be >= 8
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_uart  in  1  asynchronous serial line, idle high
rx_ready  in  1  consumer accepts rx_data this cycle
rx_data  out  DATA_BITS  received word, LSB = first bit on the wire
rx_valid  out  1  rx_data, parity_err and frame_err are valid; held until accepted
parity_err  out  1  parity mismatch on the held word (always 0 when PARITY_MODE = 0)
frame_err  out  1  a stop bit sampled 0 on the held word
break_det  out  1  one-cycle pulse on a break condition
overrun  out  1  one-cycle pulse when a completed frame is dropped
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: rx_data = 0; rx_valid, parity_err, frame_err, break_det, overrun, busy = 0; state = IDLE; counters = 0. Both synchroniser flops reset to 1 (line idle). Reset mid-frame discards the partial frame.
- Synchroniser: rx_uart passes through 2 flops. All logic uses the synchronised bit rx_s.
- MID = (CLKS_PER_BIT-1)/2, integer division.
- Bit counter runs 0..CLKS_PER_BIT-1 within each bit period.
- Majority vote: rx_s is sampled at counts MID-1, MID and MID+1. The bit value is the majority of the three, decided in the count MID+1 cycle.
- States:
  - IDLE: counter cleared; rx_s = 0 -> START.
  - START: at the decision point, majority 1 -> IDLE (glitch, nothing reported); majority 0 -> DATA.
  - DATA: DATA_BITS bits, LSB first, shifted into a shift register; after the last bit -> PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: compare the sampled bit with XOR(data) (even) or ~XOR(data) (odd); record the mismatch.
  - STOP: STOP_BITS bits; any stop bit with majority 0 sets the frame-error flag. At the last stop decision: if the frame error is clear -> IDLE; if it is set -> WAIT_HIGH.
  - WAIT_HIGH: remain until rx_s = 1, then -> IDLE. This prevents a break or a low line from retriggering a start.
- Frame completion is the last stop-bit decision cycle.
  - Break case: data all zero, parity bit (if present) 0 and frame error set. break_det pulses for 1 cycle on the next edge; no word is delivered and the holding register is untouched.
  - Otherwise: deliver the word with its parity_err and frame_err flags.
- Delivery, on the edge after completion:
  - If the register is empty (rx_valid = 0), or rx_valid & rx_ready in the completion cycle: load rx_data and the flags, and set rx_valid = 1.
  - Else: drop the new word, keep the old word and flags, and pulse overrun for 1 cycle.
- Handshake: rx_valid & rx_ready with no simultaneous load -> rx_valid = 0 on the next edge. rx_data holds its last value; the flags clear.
- Latency: rx_valid rises 2 (sync) + (1 + DATA_BITS + P + STOP_BITS - 1) × CLKS_PER_BIT + MID + 2 cycles after the rx_uart falling edge of the start bit, where P = 1 if parity is enabled, else 0. The bench checks this within ±1 cycle.
- Resync: the next start edge is accepted from IDLE immediately after the last stop decision, so the receiver tolerates a half-bit clock mismatch.

Test Plan:
- CLKS_PER_BIT=16, 8N1, send 0xA5, rx_ready=1 -> rx_valid one cycle, rx_data=0xA5, parity_err=0, frame_err=0, latency within ±1 of the formula.
- 8E1, send 0x03 with wrong parity bit 1 -> rx_data=0x03, parity_err=1; 8O1, send 0x03 with parity 1 -> parity_err=0.
- 1-cycle low glitch of 3 clocks on an idle line -> START aborts, busy returns 0, no rx_valid. A single-clock flipped sample at a data-bit centre is corrected by the majority vote.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once at the 0x22 completion. Then rx_ready=1 -> rx_valid drops.
- Completion coincident with rx_valid & rx_ready -> new word loaded, rx_valid stays 1, no overrun.
- Line held low for 20 bit times -> single break_det pulse, no rx_valid, state held in WAIT_HIGH. Line high then 0x5A sent -> received correctly. Also: rst_n asserted mid-DATA -> all outputs 0 and the next frame received correctly.
